// File: rtl/mem_access_stage.sv
// mem_access_stage: consumer side of the EX/MEM register. Issues the data
// memory access over a req/ack handshake, resolves branch/jump redirects,
// and drives the registered MEM/WB slot.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_alu_result,
    input  logic        in_zero,
    input  logic [2:0]  in_funct3,
    input  logic        in_branch,
    input  logic        in_jal,
    input  logic        in_jalr,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_mem_write_data,
    input  logic        in_reg_write,
    input  logic        in_mem_reg,
    input  logic        in_mem_write,
    input  logic [31:0] in_PC,
    input  logic [31:0] in_nextPC,
    input  logic [4:0]  in_write_reg,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        out_valid,
    output logic        out_reg_write,
    output logic [4:0]  out_write_reg,
    output logic [31:0] out_wb_data,
    output logic        out_misalign,
    output logic        out_bus_err
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state_q;
    logic          req_q, we_q;
    logic [31:0]   addr_q, wdata_q;
    logic [3:0]    be_q;
    logic [CW-1:0] wd_q;
    logic          ov_q, orw_q, omis_q, oerr_q;
    logic [4:0]    ord_q;
    logic [31:0]   owb_q;

    logic          is_mem, aligned, mem_op, misaligned, wd_expire, rw_ok, taken;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_data, st_data, wb_data;
    logic [3:0]    st_be;

    // Alignment check, mem_op qualification and watchdog expiry.
    always_comb begin
        is_mem = in_mem_reg | in_mem_write;
        case (in_funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~in_alu_result[0];
            default: aligned = (in_alu_result[1:0] == 2'b00);
        endcase
        mem_op     = in_valid & is_mem & aligned;
        misaligned = in_valid & is_mem & ~aligned;
        rw_ok      = in_valid & in_reg_write & (in_write_reg != 5'd0);
        wd_expire  = (TIMEOUT != 0) && (state_q == ACCESS) && !dmem_ack && (wd_q == WD_LAST);
        stall      = ((state_q == IDLE) & mem_op) |
                     ((state_q == ACCESS) & ~dmem_ack & ~wd_expire);
    end

    // Load lane extraction and writeback source selection.
    always_comb begin
        case (in_alu_result[1:0])
            2'b00:   ld_byte = dmem_rdata[7:0];
            2'b01:   ld_byte = dmem_rdata[15:8];
            2'b10:   ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = in_alu_result[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (in_funct3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = dmem_rdata;
        endcase
        if (in_jal | in_jalr)  wb_data = in_nextPC;
        else if (in_mem_reg)   wb_data = ld_data;
        else                   wb_data = in_alu_result;
    end

    // Store lane replication and byte enables.
    always_comb begin
        case (in_funct3[1:0])
            2'b00: begin
                st_data = {4{in_mem_write_data[7:0]}};
                st_be   = 4'b0001 << in_alu_result[1:0];
            end
            2'b01: begin
                st_data = {2{in_mem_write_data[15:0]}};
                st_be   = in_alu_result[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_data = in_mem_write_data;
                st_be   = 4'b1111;
            end
        endcase
    end

    // Branch condition and PC redirect.
    always_comb begin
        case (in_funct3)
            3'b000:         taken = in_zero;
            3'b001:         taken = ~in_zero;
            3'b100, 3'b110: taken = in_alu_result[0];
            3'b101, 3'b111: taken = ~in_alu_result[0];
            default:        taken = 1'b0;
        endcase
        pc_redirect = in_valid & (in_jal | in_jalr | (in_branch & taken));
        pc_target   = in_jalr ? {in_alu_result[31:1], 1'b0} : in_PC + in_imm;
    end

    // Access FSM with registered request and MEM/WB outputs.
    // Upstream is stalled during ACCESS, so in_* still describe the pending op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            wd_q    <= '0;
            ov_q    <= 1'b0;
            orw_q   <= 1'b0;
            ord_q   <= '0;
            owb_q   <= '0;
            omis_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            omis_q <= 1'b0;
            oerr_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (mem_op) begin
                        state_q <= ACCESS;
                        req_q   <= 1'b1;
                        we_q    <= in_mem_write;
                        addr_q  <= {in_alu_result[31:2], 2'b00};
                        wdata_q <= st_data;
                        be_q    <= in_mem_write ? st_be : 4'b0000;
                        wd_q    <= '0;
                        ov_q    <= 1'b0;
                        orw_q   <= 1'b0;
                    end else begin
                        ov_q   <= in_valid;
                        orw_q  <= rw_ok & ~misaligned;
                        ord_q  <= in_write_reg;
                        owb_q  <= wb_data;
                        omis_q <= misaligned;
                    end
                end
                ACCESS: begin
                    if (dmem_ack || wd_expire) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        be_q    <= '0;
                        ov_q    <= 1'b1;
                        orw_q   <= dmem_ack & rw_ok;
                        ord_q   <= in_write_reg;
                        owb_q   <= wb_data;
                        oerr_q  <= ~dmem_ack;
                    end else begin
                        wd_q <= wd_q + CW'(1);
                    end
                end
            endcase
        end
    end

    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_wdata    = wdata_q;
    assign dmem_be       = be_q;
    assign out_valid     = ov_q;
    assign out_reg_write = orw_q;
    assign out_write_reg = ord_q;
    assign out_wb_data   = owb_q;
    assign out_misalign  = omis_q;
    assign out_bus_err   = oerr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage with a
// transaction-level reference model.
module tb_mem_access_stage;

    localparam int unsigned TB_TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_zero, in_branch, in_jal, in_jalr;
    logic        in_reg_write, in_mem_reg, in_mem_write;
    logic [31:0] in_alu_result, in_imm, in_mem_write_data, in_PC, in_nextPC;
    logic [2:0]  in_funct3;
    logic [4:0]  in_write_reg;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        stall, pc_redirect;
    logic [31:0] pc_target;
    logic        out_valid, out_reg_write, out_misalign, out_bus_err;
    logic [4:0]  out_write_reg;
    logic [31:0] out_wb_data;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        logic        valid, zero, br, jal, jalr, rw, mr, mw;
        logic [2:0]  f3;
        logic [31:0] alu, imm, sd, pc;
        logic [4:0]  rd;
    } instr_t;

    mem_access_stage #(.TIMEOUT(TB_TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_alu_result(in_alu_result), .in_zero(in_zero),
        .in_funct3(in_funct3), .in_branch(in_branch), .in_jal(in_jal), .in_jalr(in_jalr),
        .in_imm(in_imm), .in_mem_write_data(in_mem_write_data), .in_reg_write(in_reg_write),
        .in_mem_reg(in_mem_reg), .in_mem_write(in_mem_write), .in_PC(in_PC),
        .in_nextPC(in_nextPC), .in_write_reg(in_write_reg),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .stall(stall), .pc_redirect(pc_redirect),
        .pc_target(pc_target), .out_valid(out_valid), .out_reg_write(out_reg_write),
        .out_write_reg(out_write_reg), .out_wb_data(out_wb_data),
        .out_misalign(out_misalign), .out_bus_err(out_bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic m_aligned(input logic [2:0] f3, input logic [31:0] a);
        if (f3[1:0] == 2'b00) return 1'b1;
        if (f3[1:0] == 2'b01) return (a % 2) == 0;
        return (a % 4) == 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * (a % 4))) & 32'hFF;
        h = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        case (f3)
            3'd0: return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd1: return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd4: return b;
            3'd5: return h;
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        if (f3[1:0] == 2'b00) return 4'(1 << (a % 4));
        if (f3[1:0] == 2'b01) return ((a % 4) < 2) ? 4'd3 : 4'd12;
        return 4'd15;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3[1:0] == 2'b00) return (d & 32'hFF) * 32'h01010101;
        if (f3[1:0] == 2'b01) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic m_taken(input logic [2:0] f3, input logic z, input logic [31:0] a);
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4, 3'd6: return (a % 2) == 1;
            3'd5, 3'd7: return (a % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(input instr_t t);
        in_valid = t.valid; in_zero = t.zero; in_branch = t.br; in_jal = t.jal;
        in_jalr = t.jalr; in_reg_write = t.rw; in_mem_reg = t.mr; in_mem_write = t.mw;
        in_funct3 = t.f3; in_alu_result = t.alu; in_imm = t.imm; in_mem_write_data = t.sd;
        in_PC = t.pc; in_nextPC = t.pc + 32'd4; in_write_reg = t.rd;
    endtask

    task automatic check_out(input logic v, input logic rw, input logic [4:0] rd,
                             input logic [31:0] wb, input logic chk_wb,
                             input logic mis, input logic err);
        chk("out_valid", 32'(out_valid), 32'(v));
        chk("out_reg_write", 32'(out_reg_write), 32'(rw));
        chk("out_misalign", 32'(out_misalign), 32'(mis));
        chk("out_bus_err", 32'(out_bus_err), 32'(err));
        if (v) chk("out_write_reg", 32'(out_write_reg), 32'(rd));
        if (chk_wb) chk("out_wb_data", out_wb_data, wb);
    endtask

    // Runs one instruction; ack_delay = ACCESS cycles without ack before ack.
    task automatic run(input instr_t t, input int ack_delay, input logic [31:0] rdata);
        logic        mem, mop, mis, redir, rwok, done;
        logic [31:0] tgt, wb;
        mem   = t.valid & (t.mr | t.mw);
        mop   = mem & m_aligned(t.f3, t.alu);
        mis   = mem & !m_aligned(t.f3, t.alu);
        redir = t.valid & (t.jal | t.jalr | (t.br & m_taken(t.f3, t.zero, t.alu)));
        tgt   = t.jalr ? (t.alu & 32'hFFFFFFFE) : t.pc + t.imm;
        wb    = (t.jal | t.jalr) ? t.pc + 32'd4 : t.mr ? m_load(t.f3, t.alu, rdata) : t.alu;
        rwok  = t.valid & t.rw & (t.rd != 0);
        drive(t);
        dmem_ack = 1'b0;
        dmem_rdata = ~rdata;
        #1;
        chk("pc_redirect", 32'(pc_redirect), 32'(redir));
        if (redir) chk("pc_target", pc_target, tgt);
        chk("stall_issue", 32'(stall), 32'(mop));
        @(posedge clk); #1;
        if (!mop) begin
            chk("no_req", 32'(dmem_req), 32'd0);
            check_out(t.valid, rwok & !mis, t.rd, wb, t.valid & !mis, mis, 1'b0);
        end else begin
            chk("req", 32'(dmem_req), 32'd1);
            chk("we", 32'(dmem_we), 32'(t.mw));
            chk("addr", dmem_addr, t.alu & 32'hFFFFFFFC);
            if (t.mw) begin
                chk("be", 32'(dmem_be), 32'(m_be(t.f3, t.alu)));
                chk("wdata", dmem_wdata, m_wdata(t.f3, t.sd));
            end
            chk("wait_valid", 32'(out_valid), 32'd0);
            done = 1'b0;
            for (int c = 0; c < 64 && !done; c++) begin
                if (c == ack_delay) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = rdata;
                    #1;
                    chk("stall_ack", 32'(stall), 32'd0);
                    @(posedge clk); #1;
                    dmem_ack = 1'b0;
                    dmem_rdata = ~rdata;
                    chk("req_drop", 32'(dmem_req), 32'd0);
                    check_out(1'b1, rwok, t.rd, wb, 1'b1, 1'b0, 1'b0);
                    done = 1'b1;
                end else if (c == int'(TB_TO) - 1) begin
                    #1;
                    chk("stall_timeout", 32'(stall), 32'd0);
                    @(posedge clk); #1;
                    chk("req_abort", 32'(dmem_req), 32'd0);
                    check_out(1'b1, 1'b0, t.rd, 32'd0, 1'b0, 1'b0, 1'b1);
                    done = 1'b1;
                end else begin
                    #1;
                    chk("stall_wait", 32'(stall), 32'd1);
                    chk("req_hold", 32'(dmem_req), 32'd1);
                    chk("addr_hold", dmem_addr, t.alu & 32'hFFFFFFFC);
                    @(posedge clk); #1;
                end
            end
            if (!done) chk("access_budget", 32'(done), 32'd1);
        end
    endtask

    function automatic instr_t blank();
        instr_t t;
        t.valid = 1'b1; t.zero = 1'b0; t.br = 1'b0; t.jal = 1'b0; t.jalr = 1'b0;
        t.rw = 1'b0; t.mr = 1'b0; t.mw = 1'b0; t.f3 = 3'd0;
        t.alu = '0; t.imm = '0; t.sd = '0; t.pc = '0; t.rd = 5'd0;
        return t;
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        int k;
        t = blank();
        k = $urandom_range(0, 6);
        t.alu = $urandom; t.imm = $urandom; t.sd = $urandom; t.pc = $urandom;
        t.rd = 5'($urandom_range(0, 31)); t.zero = 1'($urandom);
        case (k)
            0: begin
                t.valid = 1'b0; t.mr = 1'($urandom); t.mw = 1'($urandom);
                t.jal = 1'($urandom); t.rw = 1'b1; t.f3 = 3'($urandom);
            end
            1: t.rw = 1'b1;
            2: begin
                t.mr = 1'b1; t.rw = 1'b1;
                case ($urandom_range(0, 4))
                    0: t.f3 = 3'd0; 1: t.f3 = 3'd1; 2: t.f3 = 3'd2;
                    3: t.f3 = 3'd4; default: t.f3 = 3'd5;
                endcase
            end
            3: begin t.mw = 1'b1; t.f3 = 3'($urandom_range(0, 2)); end
            4: begin
                t.br = 1'b1;
                case ($urandom_range(0, 5))
                    0: t.f3 = 3'd0; 1: t.f3 = 3'd1; 2: t.f3 = 3'd4;
                    3: t.f3 = 3'd5; 4: t.f3 = 3'd6; default: t.f3 = 3'd7;
                endcase
            end
            5: begin t.jal = 1'b1; t.rw = 1'b1; end
            default: begin t.jalr = 1'b1; t.rw = 1'b1; end
        endcase
        return t;
    endfunction

    initial begin
        instr_t t;
        rst_n = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        t = blank();
        t.valid = 1'b0;
        drive(t);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_bus_err", 32'(out_bus_err), 32'd0);
        rst_n = 1'b1;

        // ALU op leaves nonzero state in MEM/WB before the reset-in-access check
        t = blank(); t.rw = 1'b1; t.rd = 5'd7; t.alu = 32'hCAFE0001;
        run(t, 0, 32'd0);

        // reset asserted while an LW waits for ack
        t = blank(); t.mr = 1'b1; t.rw = 1'b1; t.f3 = 3'd2; t.alu = 32'h100; t.rd = 5'd3;
        drive(t);
        @(posedge clk); #1;
        chk("pre_rst_req", 32'(dmem_req), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_req", 32'(dmem_req), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_rw", 32'(out_reg_write), 32'd0);
        chk("midrst_wb", out_wb_data, 32'd0);
        chk("midrst_rd", 32'(out_write_reg), 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        t = blank(); t.valid = 1'b0;
        run(t, 0, 32'd0);

        // LB / LBU at 0x103, ack on the 4th ACCESS cycle
        t = blank(); t.mr = 1'b1; t.rw = 1'b1; t.f3 = 3'd0; t.alu = 32'h103; t.rd = 5'd5;
        run(t, 3, 32'h80000000);
        t.f3 = 3'd4;
        run(t, 3, 32'h80000000);
        // SH at 0x202
        t = blank(); t.mw = 1'b1; t.f3 = 3'd1; t.alu = 32'h202; t.sd = 32'h0000BEEF;
        run(t, 1, 32'd0);
        // misaligned LW at 0x6
        t = blank(); t.mr = 1'b1; t.rw = 1'b1; t.f3 = 3'd2; t.alu = 32'h6; t.rd = 5'd9;
        run(t, 0, 32'd0);
        // BNE taken, then jalr
        t = blank(); t.br = 1'b1; t.f3 = 3'd1; t.zero = 1'b0; t.pc = 32'h40; t.imm = 32'h10;
        run(t, 0, 32'd0);
        t = blank(); t.jalr = 1'b1; t.rw = 1'b1; t.rd = 5'd1; t.alu = 32'h1235; t.pc = 32'h44;
        run(t, 0, 32'd0);
        // watchdog: no ack, then the next instruction proceeds, then ack on the last cycle
        t = blank(); t.mr = 1'b1; t.rw = 1'b1; t.f3 = 3'd2; t.alu = 32'h300; t.rd = 5'd4;
        run(t, 1000, 32'd0);
        t = blank(); t.rw = 1'b1; t.rd = 5'd2; t.alu = 32'h1111;
        run(t, 0, 32'd0);
        t = blank(); t.mr = 1'b1; t.rw = 1'b1; t.f3 = 3'd2; t.alu = 32'h304; t.rd = 5'd4;
        run(t, int'(TB_TO) - 1, 32'h12345678);

        for (int i = 0; i < 300; i++) begin
            t = rand_instr();
            run(t, $urandom_range(0, 5), $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
